// File: rtl/char_console_if.sv
// Console controller bus: CPU-side byte stream plus the char buffer port.
// The slave modport is the controller; the master modport is the CPU/RAM side.
interface char_console_if #(
  parameter int unsigned ADDR_W = 12
) ();
  logic              char_valid;
  logic [7:0]        char_data;
  logic              char_ready;
  logic              clear_req;
  logic              busy;
  logic [6:0]        cursor_col;
  logic [4:0]        cursor_row;
  logic [ADDR_W-1:0] ram_address;
  logic              ram_chipselect;
  logic              ram_write;
  logic [7:0]        ram_writedata;
  logic [7:0]        ram_readdata;

  modport master (
    output char_valid, char_data, clear_req, ram_readdata,
    input  char_ready, busy, cursor_col, cursor_row,
    input  ram_address, ram_chipselect, ram_write, ram_writedata
  );

  modport slave (
    input  char_valid, char_data, clear_req, ram_readdata,
    output char_ready, busy, cursor_col, cursor_row,
    output ram_address, ram_chipselect, ram_write, ram_writedata
  );
endinterface

// File: rtl/char_console_ctrl.sv
// Text console sequencer: owns the char buffer port, tracks the cursor and performs
// character writes, one-row scroll-up and full-screen clear.
module char_console_ctrl #(
  parameter int unsigned COLS      = 80,
  parameter int unsigned ROWS      = 30,
  parameter int unsigned ADDR_W    = 12,
  parameter logic [7:0]  FILL_CHAR = 8'h20
) (
  input logic           clk,
  input logic           reset,
  char_console_if.slave bus
);

  typedef enum logic [2:0] {
    StIdle, StPut, StScrRd, StScrWait, StScrWr, StFill, StClear
  } state_e;

  localparam logic [ADDR_W-1:0] ColsA      = ADDR_W'(COLS);
  localparam logic [ADDR_W-1:0] ScrollLast = ADDR_W'(COLS * (ROWS - 1) - 1);
  localparam logic [ADDR_W-1:0] FillBase   = ADDR_W'(COLS * (ROWS - 1));
  localparam logic [ADDR_W-1:0] CellLast   = ADDR_W'(COLS * ROWS - 1);
  localparam logic [6:0]        ColLast    = 7'(COLS - 1);
  localparam logic [4:0]        RowLast    = 5'(ROWS - 1);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W-1:0] idx_q, idx_d;
  logic              cs_q, cs_d;
  logic              we_q, we_d;
  logic [7:0]        wdata_q, wdata_d;
  logic [6:0]        col_q, col_d;
  logic [4:0]        row_q, row_d;
  logic              wrap_q, wrap_d;
  logic              busy_q;
  logic [ADDR_W-1:0] cur_addr;

  assign cur_addr = ADDR_W'(row_q) * ColsA + ADDR_W'(col_q);

  assign bus.char_ready     = (state_q == StIdle) & ~bus.clear_req & ~reset;
  assign bus.busy           = busy_q;
  assign bus.cursor_col     = col_q;
  assign bus.cursor_row     = row_q;
  assign bus.ram_address    = addr_q;
  assign bus.ram_chipselect = cs_q;
  assign bus.ram_write      = we_q;
  assign bus.ram_writedata  = wdata_q;

  // All ram_* values are computed for the state being entered, so they are registered.
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    idx_d   = idx_q;
    cs_d    = 1'b0;
    we_d    = 1'b0;
    wdata_d = wdata_q;
    col_d   = col_q;
    row_d   = row_q;
    wrap_d  = wrap_q;
    unique case (state_q)
      StIdle: begin
        if (bus.clear_req) begin
          state_d = StClear;
          col_d   = '0;
          row_d   = '0;
          addr_d  = '0;
          cs_d    = 1'b1;
          we_d    = 1'b1;
          wdata_d = FILL_CHAR;
        end else if (bus.char_valid) begin
          if (bus.char_data inside {[8'h20:8'h7E]}) begin
            state_d = StPut;
            addr_d  = cur_addr;
            cs_d    = 1'b1;
            we_d    = 1'b1;
            wdata_d = bus.char_data;
            wrap_d  = 1'b0;
            if (col_q == ColLast) begin
              col_d = '0;
              if (row_q == RowLast) wrap_d = 1'b1;
              else                  row_d  = row_q + 5'd1;
            end else begin
              col_d = col_q + 7'd1;
            end
          end else if (bus.char_data == 8'h0A) begin
            col_d = '0;
            if (row_q == RowLast) begin
              state_d = StScrRd;
              idx_d   = '0;
              addr_d  = ColsA;
              cs_d    = 1'b1;
            end else begin
              row_d = row_q + 5'd1;
            end
          end else if (bus.char_data == 8'h0D) begin
            col_d = '0;
          end else if (bus.char_data == 8'h08 && col_q != '0) begin
            col_d = col_q - 7'd1;
          end
        end
      end
      StPut: begin
        if (wrap_q) begin
          state_d = StScrRd;
          idx_d   = '0;
          addr_d  = ColsA;
          cs_d    = 1'b1;
        end else begin
          state_d = StIdle;
        end
      end
      StScrRd: state_d = StScrWait;
      StScrWait: begin
        state_d = StScrWr;
        addr_d  = idx_q;
        cs_d    = 1'b1;
        we_d    = 1'b1;
        wdata_d = bus.ram_readdata;
      end
      StScrWr: begin
        cs_d = 1'b1;
        if (idx_q == ScrollLast) begin
          state_d = StFill;
          addr_d  = FillBase;
          we_d    = 1'b1;
          wdata_d = FILL_CHAR;
        end else begin
          state_d = StScrRd;
          idx_d   = idx_q + 1'b1;
          addr_d  = idx_q + 1'b1 + ColsA;
        end
      end
      StFill, StClear: begin
        if (addr_q == CellLast) begin
          state_d = StIdle;
        end else begin
          addr_d = addr_q + 1'b1;
          cs_d   = 1'b1;
          we_d   = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      addr_q  <= '0;
      idx_q   <= '0;
      cs_q    <= 1'b0;
      we_q    <= 1'b0;
      wdata_q <= '0;
      col_q   <= '0;
      row_q   <= '0;
      wrap_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      idx_q   <= idx_d;
      cs_q    <= cs_d;
      we_q    <= we_d;
      wdata_q <= wdata_d;
      col_q   <= col_d;
      row_q   <= row_d;
      wrap_q  <= wrap_d;
      busy_q  <= (state_d != StIdle);
    end
  end

endmodule

// File: tb/tb_char_console_ctrl.sv
// Randomized bench for char_console_ctrl: a RAM model plus a screen/cursor reference model.
module tb_char_console_ctrl;
  localparam int COLS  = 80;
  localparam int ROWS  = 30;
  localparam int CELLS = COLS * ROWS;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  char_console_if #(.ADDR_W(12)) bus ();

  char_console_ctrl #(
    .COLS(80), .ROWS(30), .ADDR_W(12), .FILL_CHAR(8'h20)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );

  // Char buffer model: 1-cycle read latency, logs every write and counts accesses.
  logic [7:0]  mem [4096];
  logic [7:0]  rd_q = 8'h00;
  logic [11:0] wlog_a [$];
  logic [7:0]  wlog_d [$];
  int          acc_cnt = 0;
  logic        preload = 1'b0;
  assign bus.ram_readdata = rd_q;

  always @(posedge clk) begin
    if (preload) begin
      for (int i = 0; i < CELLS; i++) mem[i] = 8'(8'h30 + i / COLS);
    end
    if (bus.ram_chipselect === 1'b1) begin
      acc_cnt++;
      if (bus.ram_write === 1'b1) begin
        mem[bus.ram_address] = bus.ram_writedata;
        wlog_a.push_back(bus.ram_address);
        wlog_d.push_back(bus.ram_writedata);
      end else begin
        rd_q <= mem[bus.ram_address];
      end
    end
  end

  // Reference model of the screen and cursor.
  logic [7:0] exp_mem [CELLS];
  int m_col = 0, m_row = 0;
  int n_checks = 0, n_pass = 0;

  task automatic model_scroll();
    for (int i = 0; i < CELLS - COLS; i++) exp_mem[i] = exp_mem[i + COLS];
    for (int i = CELLS - COLS; i < CELLS; i++) exp_mem[i] = 8'h20;
  endtask

  task automatic model_byte(input logic [7:0] b);
    if (b >= 8'h20 && b <= 8'h7E) begin
      exp_mem[m_row * COLS + m_col] = b;
      m_col++;
      if (m_col == COLS) begin m_col = 0; m_row++; end
    end else if (b == 8'h0A) begin
      m_col = 0; m_row++;
    end else if (b == 8'h0D) begin
      m_col = 0;
    end else if (b == 8'h08 && m_col > 0) begin
      m_col--;
    end
    if (m_row == ROWS) begin model_scroll(); m_row = ROWS - 1; end
  endtask

  task automatic send_byte(input logic [7:0] b);
    int w = 0;
    bus.char_valid = 1'b1;
    bus.char_data  = b;
    while (bus.char_ready !== 1'b1 && w < 10000) begin @(negedge clk); w++; end
    if (bus.char_ready !== 1'b1) begin
      n_checks++;
      $display("FAIL send_accept: char_ready=%b after %0d cycles, expected 1", bus.char_ready, w);
    end
    @(negedge clk);
    bus.char_valid = 1'b0;
  endtask

  task automatic wait_idle(output int cycles);
    cycles = 0;
    while (bus.busy !== 1'b0 && cycles < 20000) begin @(negedge clk); cycles++; end
  endtask

  function automatic logic [7:0] rand_print();
    return 8'($urandom_range(8'h20, 8'h7E));
  endfunction

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    repeat (10) @(negedge clk);
    m_col = 0; m_row = 0;
    n_checks++;
    if ({bus.ram_chipselect, bus.ram_write, bus.busy, bus.char_ready} !== 4'b0001)
      $display("FAIL reset_ctrl: cs/we/busy/ready=%b, expected 0001",
               {bus.ram_chipselect, bus.ram_write, bus.busy, bus.char_ready});
    else n_pass++;
    n_checks++;
    if ({bus.cursor_col, bus.cursor_row, bus.ram_address, bus.ram_writedata} !== 32'h0)
      $display("FAIL reset_regs: col=%0d row=%0d addr=%0d wdata=%h, expected all 0",
               bus.cursor_col, bus.cursor_row, bus.ram_address, bus.ram_writedata);
    else n_pass++;
  endtask

  task automatic test_single_put();
    int wb = wlog_a.size();
    send_byte(8'h41);
    model_byte(8'h41);
    n_checks++;
    if ({bus.ram_chipselect, bus.ram_write, bus.ram_address, bus.ram_writedata} !== {2'b11, 12'd0, 8'h41})
      $display("FAIL put_bus: cs=%b we=%b addr=%0d data=%h, expected 1 1 0 41",
               bus.ram_chipselect, bus.ram_write, bus.ram_address, bus.ram_writedata);
    else n_pass++;
    n_checks++;
    if (bus.cursor_col !== 7'(m_col) || bus.cursor_row !== 5'(m_row) || bus.char_ready !== 1'b0)
      $display("FAIL put_cursor: col=%0d row=%0d ready=%b, expected %0d %0d 0",
               bus.cursor_col, bus.cursor_row, bus.char_ready, m_col, m_row);
    else n_pass++;
    @(negedge clk);
    n_checks++;
    if (bus.char_ready !== 1'b1 || wlog_a.size() - wb != 1)
      $display("FAIL put_done: ready=%b writes=%0d, expected 1 1", bus.char_ready, wlog_a.size() - wb);
    else n_pass++;
  endtask

  task automatic test_clear_priority();
    int wb = wlog_a.size(), c = 0, bad = 0;
    bus.clear_req = 1'b1; bus.char_valid = 1'b1; bus.char_data = 8'h42;
    #1;
    n_checks++;
    if (bus.char_ready !== 1'b0) $display("FAIL clear_ready: ready=%b, expected 0", bus.char_ready);
    else n_pass++;
    @(negedge clk);
    bus.clear_req = 1'b0;
    n_checks++;
    if ({bus.busy, bus.ram_write, bus.ram_address, bus.ram_writedata, bus.cursor_col, bus.cursor_row}
        !== {2'b11, 12'd0, 8'h20, 7'd0, 5'd0})
      $display("FAIL clear_start: busy=%b we=%b addr=%0d data=%h col=%0d row=%0d, expected 1 1 0 20 0 0",
               bus.busy, bus.ram_write, bus.ram_address, bus.ram_writedata, bus.cursor_col, bus.cursor_row);
    else n_pass++;
    while (bus.busy !== 1'b0 && c < 5000) begin @(negedge clk); c++; end
    n_checks++;
    if (c != CELLS) $display("FAIL clear_cycles: busy for %0d cycles, expected %0d", c, CELLS);
    else n_pass++;
    @(negedge clk);
    bus.char_valid = 1'b0;
    @(negedge clk);
    for (int i = 0; i < CELLS; i++) begin
      exp_mem[i] = 8'h20;
      if (wb + i >= wlog_a.size() || wlog_a[wb + i] != 12'(i) || wlog_d[wb + i] != 8'h20) bad++;
    end
    m_col = 0; m_row = 0;
    model_byte(8'h42);
    n_checks++;
    if (bad != 0 || wlog_a.size() - wb != CELLS + 1)
      $display("FAIL clear_writes: %0d bad entries, %0d writes, expected 0 bad, %0d writes",
               bad, wlog_a.size() - wb, CELLS + 1);
    else n_pass++;
    n_checks++;
    if (wlog_a[$] !== 12'd0 || wlog_d[$] !== 8'h42 || bus.cursor_col !== 7'd1)
      $display("FAIL clear_then_char: addr=%0d data=%h col=%0d, expected 0 42 1",
               wlog_a[$], wlog_d[$], bus.cursor_col);
    else n_pass++;
  endtask

  task automatic test_row_fill();
    int wb, ab, c, bad = 0;
    logic [7:0] sent [COLS];
    send_byte(8'h0D); model_byte(8'h0D);
    wb = wlog_a.size(); ab = acc_cnt;
    for (int i = 0; i < COLS; i++) begin
      sent[i] = rand_print();
      send_byte(sent[i]); model_byte(sent[i]);
    end
    wait_idle(c);
    @(negedge clk);
    for (int i = 0; i < COLS; i++)
      if (wb + i >= wlog_a.size() || wlog_a[wb + i] != 12'(i) || wlog_d[wb + i] != sent[i]) bad++;
    n_checks++;
    if (bad != 0 || acc_cnt - ab != COLS)
      $display("FAIL row_writes: %0d bad, %0d accesses, expected 0 bad, %0d accesses",
               bad, acc_cnt - ab, COLS);
    else n_pass++;
    n_checks++;
    if (bus.cursor_col !== 7'd0 || bus.cursor_row !== 5'd1 || bus.busy !== 1'b0)
      $display("FAIL row_cursor: col=%0d row=%0d busy=%b, expected 0 1 0",
               bus.cursor_col, bus.cursor_row, bus.busy);
    else n_pass++;
  endtask

  task automatic test_bs_cr();
    int ab = acc_cnt;
    send_byte(8'h08); model_byte(8'h08);
    n_checks++;
    if (bus.cursor_col !== 7'd0 || acc_cnt != ab)
      $display("FAIL bs_at_col0: col=%0d accesses=%0d, expected 0 0", bus.cursor_col, acc_cnt - ab);
    else n_pass++;
    for (int i = 0; i < 5; i++) begin send_byte(8'h61 + 8'(i)); model_byte(8'h61 + 8'(i)); end
    @(negedge clk);
    ab = acc_cnt;
    send_byte(8'h08); model_byte(8'h08);
    @(negedge clk);
    n_checks++;
    if (bus.cursor_col !== 7'd4 || acc_cnt != ab)
      $display("FAIL bs_mid: col=%0d accesses=%0d, expected 4 0", bus.cursor_col, acc_cnt - ab);
    else n_pass++;
    send_byte(8'h66); model_byte(8'h66);
    @(negedge clk);
    ab = acc_cnt;
    send_byte(8'h0D); model_byte(8'h0D);
    @(negedge clk);
    n_checks++;
    if (bus.cursor_col !== 7'd0 || bus.cursor_row !== 5'(m_row) || acc_cnt != ab)
      $display("FAIL cr: col=%0d row=%0d accesses=%0d, expected 0 %0d 0",
               bus.cursor_col, bus.cursor_row, acc_cnt - ab, m_row);
    else n_pass++;
  endtask

  task automatic test_random_stream();
    int c, sel;
    logic [7:0] b;
    for (int n = 0; n < 150; n++) begin
      sel = $urandom_range(0, 99);
      if (sel < 70)      b = rand_print();
      else if (sel < 80) b = 8'h0A;
      else if (sel < 87) b = 8'h0D;
      else if (sel < 94) b = 8'h08;
      else if (sel < 97) b = 8'($urandom_range(0, 8'h07));
      else               b = 8'($urandom_range(8'h7F, 8'hFF));
      send_byte(b); model_byte(b);
      wait_idle(c);
      n_checks++;
      if (bus.cursor_col !== 7'(m_col) || bus.cursor_row !== 5'(m_row))
        $display("FAIL rand_cursor[%0d] byte %h: col=%0d row=%0d, expected %0d %0d",
                 n, b, bus.cursor_col, bus.cursor_row, m_col, m_row);
      else n_pass++;
    end
  endtask

  task automatic test_screen(input string tag);
    int bad = 0, first = -1;
    @(negedge clk);
    for (int i = 0; i < CELLS; i++)
      if (mem[i] !== exp_mem[i]) begin bad++; if (first < 0) first = i; end
    n_checks++;
    if (bad != 0)
      $display("FAIL screen_%s: %0d cells differ, first at %0d got %h expected %h",
               tag, bad, first, mem[first], exp_mem[first]);
    else n_pass++;
  endtask

  task automatic test_scroll();
    int c, ab;
    send_byte(8'h0D); model_byte(8'h0D);
    while (m_row < ROWS - 1) begin send_byte(8'h0A); model_byte(8'h0A); end
    preload = 1'b1;
    @(negedge clk);
    preload = 1'b0;
    for (int i = 0; i < CELLS; i++) exp_mem[i] = 8'(8'h30 + i / COLS);
    ab = acc_cnt;
    send_byte(8'h0A); model_byte(8'h0A);
    wait_idle(c);
    n_checks++;
    if (c != 3 * COLS * (ROWS - 1) + COLS)
      $display("FAIL scroll_cycles: busy for %0d, expected %0d", c, 3 * COLS * (ROWS - 1) + COLS);
    else n_pass++;
    n_checks++;
    if (acc_cnt - ab != 2 * COLS * (ROWS - 1) + COLS || bus.cursor_col !== 7'd0 ||
        bus.cursor_row !== 5'd29)
      $display("FAIL scroll_state: accesses=%0d col=%0d row=%0d, expected %0d 0 29",
               acc_cnt - ab, bus.cursor_col, bus.cursor_row, 2 * COLS * (ROWS - 1) + COLS);
    else n_pass++;
    test_screen("scroll_nl");
    for (int i = 0; i < COLS; i++) begin
      logic [7:0] b = rand_print();
      send_byte(b); model_byte(b);
    end
    wait_idle(c);
    n_checks++;
    if (c != 1 + 3 * COLS * (ROWS - 1) + COLS || bus.cursor_col !== 7'd0 || bus.cursor_row !== 5'd29)
      $display("FAIL wrap_scroll: busy=%0d col=%0d row=%0d, expected %0d 0 29",
               c, bus.cursor_col, bus.cursor_row, 1 + 3 * COLS * (ROWS - 1) + COLS);
    else n_pass++;
    test_screen("scroll_wrap");
  endtask

  task automatic test_reset_mid_scroll();
    int ab;
    send_byte(8'h0A);
    repeat (99) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    n_checks++;
    if ({bus.busy, bus.ram_write, bus.ram_chipselect, bus.cursor_col, bus.cursor_row} !== 15'd0)
      $display("FAIL mid_reset: busy=%b we=%b cs=%b col=%0d row=%0d, expected all 0",
               bus.busy, bus.ram_write, bus.ram_chipselect, bus.cursor_col, bus.cursor_row);
    else n_pass++;
    reset = 1'b0;
    m_col = 0; m_row = 0;
    ab = acc_cnt;
    repeat (5) @(negedge clk);
    n_checks++;
    if (acc_cnt != ab || bus.char_ready !== 1'b1)
      $display("FAIL post_reset_idle: accesses=%0d ready=%b, expected 0 1", acc_cnt - ab, bus.char_ready);
    else n_pass++;
    send_byte(8'h43);
    @(negedge clk);
    n_checks++;
    if (wlog_a[$] !== 12'd0 || wlog_d[$] !== 8'h43 || acc_cnt - ab != 1)
      $display("FAIL post_reset_put: addr=%0d data=%h accesses=%0d, expected 0 43 1",
               wlog_a[$], wlog_d[$], acc_cnt - ab);
    else n_pass++;
  endtask

  initial begin
    bus.char_valid = 1'b0;
    bus.char_data  = 8'h00;
    bus.clear_req  = 1'b0;
    @(negedge clk);
    test_reset();
    test_single_put();
    test_clear_priority();
    test_row_fill();
    test_bs_cr();
    test_random_stream();
    test_screen("random");
    test_scroll();
    test_reset_mid_scroll();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
